// File: rtl/reg_file_alu_pipe.sv
// Register file plus ALU as a two-stage pipeline: stage 1 reads operands (with a
// bypass from the executing op), stage 2 computes, writes back and updates NZCV.
module reg_file_alu_pipe #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  input  logic [ADDR_W-1:0] WA,
  input  logic              RegWrite,
  input  logic              ALUSrc,
  input  logic [2:0]        ALUControl,
  input  logic [DATA_W-1:0] external_data_in,
  output logic [DATA_W-1:0] ALUResult,
  output logic              out_valid,
  output logic [3:0]        flags,
  input  logic [ADDR_W-1:0] DA,
  output logic [DATA_W-1:0] DD
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam int SH_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int MSB   = DATA_W - 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  logic [DATA_W-1:0] regs_r [NREGS];

  logic              s1_valid_r;
  logic [DATA_W-1:0] s1_a_r;
  logic [DATA_W-1:0] s1_b_r;
  logic [ADDR_W-1:0] s1_wa_r;
  logic              s1_we_r;
  logic [2:0]        s1_op_r;

  logic [DATA_W:0]   sum_s;
  logic [DATA_W:0]   diff_s;
  logic [DATA_W-1:0] alu_res_s;
  logic              carry_s;
  logic              ovf_s;
  logic [3:0]        alu_flags_s;
  logic              wb_en_s;
  logic [DATA_W-1:0] rd_a_s;
  logic [DATA_W-1:0] rd_b_s;
  logic [DATA_W-1:0] opa_s;
  logic [DATA_W-1:0] opb_s;

  // Writes to a hardwired R0 are dropped here, which also disables the R0 bypass.
  assign wb_en_s = s1_valid_r && s1_we_r && !(R0_ZERO && (s1_wa_r == {ADDR_W{1'b0}}));

  assign DD = (R0_ZERO && (DA == {ADDR_W{1'b0}})) ? {DATA_W{1'b0}} : regs_r[DA];

  // ALU and flag generation for the op held in stage 1.
  always_comb begin
    sum_s     = {1'b0, s1_a_r} + {1'b0, s1_b_r};
    diff_s    = {1'b0, s1_a_r} - {1'b0, s1_b_r};
    alu_res_s = {DATA_W{1'b0}};
    carry_s   = 1'b0;
    ovf_s     = 1'b0;
    case (s1_op_r)
      OP_ADD: begin
        alu_res_s = sum_s[DATA_W-1:0];
        carry_s   = sum_s[DATA_W];
        ovf_s     = (s1_a_r[MSB] == s1_b_r[MSB]) && (sum_s[MSB] != s1_a_r[MSB]);
      end
      OP_SUB: begin
        alu_res_s = diff_s[DATA_W-1:0];
        carry_s   = diff_s[DATA_W];
        ovf_s     = (s1_a_r[MSB] != s1_b_r[MSB]) && (diff_s[MSB] != s1_a_r[MSB]);
      end
      OP_AND:  alu_res_s = s1_a_r & s1_b_r;
      OP_OR:   alu_res_s = s1_a_r | s1_b_r;
      OP_XOR:  alu_res_s = s1_a_r ^ s1_b_r;
      OP_SLL:  alu_res_s = s1_a_r << s1_b_r[SH_W-1:0];
      OP_SRL:  alu_res_s = s1_a_r >> s1_b_r[SH_W-1:0];
      OP_PASS: alu_res_s = s1_b_r;
      default: alu_res_s = s1_b_r;
    endcase
    alu_flags_s = {alu_res_s[MSB], (alu_res_s == {DATA_W{1'b0}}), carry_s, ovf_s};
  end

  // Operand read with forwarding of the result being written back this edge.
  always_comb begin
    rd_a_s = (R0_ZERO && (RA1 == {ADDR_W{1'b0}})) ? {DATA_W{1'b0}} : regs_r[RA1];
    rd_b_s = (R0_ZERO && (RA2 == {ADDR_W{1'b0}})) ? {DATA_W{1'b0}} : regs_r[RA2];
    if (wb_en_s && (s1_wa_r == RA1)) begin
      opa_s = alu_res_s;
    end else begin
      opa_s = rd_a_s;
    end
    if (ALUSrc) begin
      opb_s = external_data_in;
    end else if (wb_en_s && (s1_wa_r == RA2)) begin
      opb_s = alu_res_s;
    end else begin
      opb_s = rd_b_s;
    end
  end

  // Register array write-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wb_en_s) begin
      regs_r[s1_wa_r] <= alu_res_s;
    end
  end

  // Stage-1 latches and registered stage-2 outputs; results hold across bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= {DATA_W{1'b0}};
      s1_b_r     <= {DATA_W{1'b0}};
      s1_wa_r    <= {ADDR_W{1'b0}};
      s1_we_r    <= 1'b0;
      s1_op_r    <= 3'b000;
      out_valid  <= 1'b0;
      ALUResult  <= {DATA_W{1'b0}};
      flags      <= 4'b0000;
    end else begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_a_r  <= opa_s;
        s1_b_r  <= opb_s;
        s1_wa_r <= WA;
        s1_we_r <= RegWrite;
        s1_op_r <= ALUControl;
      end
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        ALUResult <= alu_res_s;
        flags     <= alu_flags_s;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_alu_pipe.sv
// Directed bench for reg_file_alu_pipe: an in-order architectural model predicts
// every output each cycle, and hand-computed results pin selected operations.
module tb_reg_file_alu_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [3:0] RA1, RA2, WA, DA;
  logic       RegWrite, ALUSrc;
  logic [2:0] ALUControl;
  logic [7:0] external_data_in;
  logic [7:0] ALUResult, DD;
  logic       out_valid;
  logic [3:0] flags;

  always #5 clk = ~clk;

  reg_file_alu_pipe #(.DATA_W(8), .ADDR_W(4), .R0_ZERO(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .RA1(RA1), .RA2(RA2), .WA(WA),
    .RegWrite(RegWrite), .ALUSrc(ALUSrc), .ALUControl(ALUControl),
    .external_data_in(external_data_in), .ALUResult(ALUResult), .out_valid(out_valid),
    .flags(flags), .DA(DA), .DD(DD)
  );

  typedef struct packed {
    logic       iv;
    logic [3:0] ra1, ra2, wa;
    logic       we, src;
    logic [2:0] op;
    logic [7:0] imm;
    logic       lit;
    logic [7:0] eres;
    logic [3:0] efl;
  } op_t;

  function automatic op_t mk(input logic [2:0] op, input logic [3:0] ra1, input logic [3:0] ra2,
                             input logic src, input logic [7:0] imm, input logic [3:0] wa,
                             input logic we, input logic [7:0] eres, input logic [3:0] efl);
    op_t o;
    o.iv = 1'b1; o.ra1 = ra1; o.ra2 = ra2; o.wa = wa; o.we = we; o.src = src;
    o.op = op; o.imm = imm; o.lit = 1'b1; o.eres = eres; o.efl = efl;
    return o;
  endfunction

  op_t nop;
  op_t prog[$];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // architectural (issue-order) and committed register views
  logic [7:0] arch [16];
  logic [7:0] comm [16];
  logic       pend_v, pend_we, pend_lit;
  logic [7:0] pend_res, pend_eres;
  logic [3:0] pend_fl, pend_efl, pend_wa;
  logic       exp_valid;
  logic [7:0] exp_res;
  logic [3:0] exp_fl;
  logic       lit_chk;
  logic [7:0] lit_res;
  logic [3:0] lit_fl;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void alu_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                    output logic [7:0] res, output logic [3:0] fl);
    int r, s, sa, sb;
    logic c, v;
    sa = (a >= 8'd128) ? int'(a) - 256 : int'(a);
    sb = (b >= 8'd128) ? int'(b) - 256 : int'(b);
    c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin r = int'(a) + int'(b); c = (r > 255); s = sa + sb; v = (s > 127) || (s < -128); end
      3'd1: begin r = int'(a) - int'(b); c = (a < b);   s = sa - sb; v = (s > 127) || (s < -128); end
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = int'(a ^ b);
      3'd5: r = int'(a) * (2 ** (int'(b) % 8));
      3'd6: r = int'(a) / (2 ** (int'(b) % 8));
      default: r = int'(b);
    endcase
    res = r[7:0];
    fl = {res[7], (res == 8'h00), c, v};
  endfunction

  task automatic model_edge(input logic rst, input op_t o);
    logic [7:0] a, b, res;
    logic [3:0] fl;
    if (rst) begin
      for (int i = 0; i < 16; i++) begin arch[i] = 8'h00; comm[i] = 8'h00; end
      pend_v = 1'b0; exp_valid = 1'b0; exp_res = 8'h00; exp_fl = 4'h0; lit_chk = 1'b0;
      return;
    end
    lit_chk = 1'b0;
    exp_valid = pend_v;
    if (pend_v) begin
      exp_res = pend_res; exp_fl = pend_fl;
      if (pend_we && pend_wa != 4'd0) comm[pend_wa] = pend_res;
      lit_chk = pend_lit; lit_res = pend_eres; lit_fl = pend_efl;
    end
    pend_v = o.iv;
    if (o.iv) begin
      a = (o.ra1 == 4'd0) ? 8'h00 : arch[o.ra1];
      b = o.src ? o.imm : ((o.ra2 == 4'd0) ? 8'h00 : arch[o.ra2]);
      alu_model(o.op, a, b, res, fl);
      if (o.we && o.wa != 4'd0) arch[o.wa] = res;
      pend_res = res; pend_fl = fl; pend_we = o.we; pend_wa = o.wa;
      pend_lit = o.lit; pend_eres = o.eres; pend_efl = o.efl;
    end
  endtask

  task automatic cyc(input logic rst, input op_t o, input logic [3:0] da);
    reset = rst; in_valid = o.iv; RA1 = o.ra1; RA2 = o.ra2; WA = o.wa;
    RegWrite = o.we; ALUSrc = o.src; ALUControl = o.op; external_data_in = o.imm; DA = da;
    @(posedge clk);
    model_edge(rst, o);
    #2;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", {7'b0, out_valid}, {7'b0, exp_valid});
      check("ALUResult", ALUResult, exp_res);
      check("flags", {4'b0, flags}, {4'b0, exp_fl});
      check("DD", DD, (DA == 4'd0) ? 8'h00 : comm[DA]);
      if (lit_chk) begin
        check("lit_result", ALUResult, lit_res);
        check("lit_flags", {4'b0, flags}, {4'b0, lit_fl});
      end
    end
  end

  initial begin
    nop = '0;
    pend_v = 1'b0;
    //           op    ra1    ra2   src imm    wa     we    res    NZCV
    prog.push_back(mk(3'd0, 4'd0, 4'd0, 1'b1, 8'h05, 4'd1, 1'b1, 8'h05, 4'b0000));
    prog.push_back(mk(3'd0, 4'd0, 4'd0, 1'b1, 8'hFB, 4'd2, 1'b1, 8'hFB, 4'b1000));
    prog.push_back(mk(3'd0, 4'd0, 4'd0, 1'b1, 8'h09, 4'd1, 1'b1, 8'h09, 4'b0000));
    prog.push_back(mk(3'd0, 4'd1, 4'd1, 1'b0, 8'h00, 4'd3, 1'b1, 8'h12, 4'b0000));
    prog.push_back(mk(3'd0, 4'd0, 4'd0, 1'b1, 8'h05, 4'd1, 1'b1, 8'h05, 4'b0000));
    prog.push_back(mk(3'd0, 4'd1, 4'd1, 1'b0, 8'h00, 4'd3, 1'b1, 8'h0A, 4'b0000));
    prog.push_back(mk(3'd0, 4'd2, 4'd1, 1'b0, 8'h00, 4'd6, 1'b1, 8'h00, 4'b0110));
    prog.push_back(mk(3'd0, 4'd0, 4'd0, 1'b1, 8'h80, 4'd4, 1'b1, 8'h80, 4'b1000));
    prog.push_back(mk(3'd1, 4'd4, 4'd0, 1'b1, 8'h01, 4'd7, 1'b1, 8'h7F, 4'b0001));
    prog.push_back(nop);
    prog.push_back(mk(3'd7, 4'd0, 4'd0, 1'b1, 8'h55, 4'd0, 1'b1, 8'h55, 4'b0000));
    prog.push_back(mk(3'd0, 4'd0, 4'd0, 1'b1, 8'h00, 4'd8, 1'b1, 8'h00, 4'b0100));
    prog.push_back(mk(3'd2, 4'd2, 4'd0, 1'b1, 8'h0F, 4'd9, 1'b1, 8'h0B, 4'b0000));
    prog.push_back(mk(3'd3, 4'd1, 4'd0, 1'b1, 8'hA0, 4'd10, 1'b1, 8'hA5, 4'b1000));
    prog.push_back(mk(3'd4, 4'd10, 4'd2, 1'b0, 8'h00, 4'd11, 1'b1, 8'h5E, 4'b0000));
    prog.push_back(mk(3'd5, 4'd1, 4'd0, 1'b1, 8'h03, 4'd12, 1'b1, 8'h28, 4'b0000));
    prog.push_back(mk(3'd6, 4'd2, 4'd0, 1'b1, 8'h0C, 4'd13, 1'b1, 8'h0F, 4'b0000));
    prog.push_back(mk(3'd1, 4'd1, 4'd2, 1'b0, 8'h00, 4'd14, 1'b1, 8'h0A, 4'b0010));
    prog.push_back(mk(3'd0, 4'd4, 4'd4, 1'b0, 8'h00, 4'd15, 1'b1, 8'h00, 4'b0111));
    prog.push_back(mk(3'd7, 4'd0, 4'd0, 1'b1, 8'h3C, 4'd1, 1'b0, 8'h3C, 4'b0000));
    prog.push_back(mk(3'd0, 4'd1, 4'd0, 1'b1, 8'h00, 4'd8, 1'b1, 8'h05, 4'b0000));

    cyc(1'b1, nop, 4'd0);
    chk_en = 1'b1;
    cyc(1'b1, nop, 4'd0);

    // Reset state across the debug port
    for (int i = 0; i < 16; i++) cyc(1'b0, nop, 4'(i));

    for (int i = 0; i < prog.size(); i++) cyc(1'b0, prog[i], (i == 0) ? 4'd0 : prog[i-1].wa);
    for (int i = 0; i < 16; i++) cyc(1'b0, nop, 4'(i));

    DA = 4'd1; #1; check("lit_DD1", DD, 8'h05);
    DA = 4'd2; #1; check("lit_DD2", DD, 8'hFB);
    DA = 4'd0; #1; check("lit_DD0", DD, 8'h00);

    // In-flight op discarded by reset
    cyc(1'b0, mk(3'd0, 4'd0, 4'd0, 1'b1, 8'h33, 4'd5, 1'b1, 8'h33, 4'b0000), 4'd5);
    cyc(1'b1, nop, 4'd5);
    check("rst_out_valid", {7'b0, out_valid}, 8'h00);
    check("rst_ALUResult", ALUResult, 8'h00);
    check("rst_DD5", DD, 8'h00);
    cyc(1'b0, nop, 4'd5);
    cyc(1'b0, nop, 4'd5);
    check("rst_out_valid_hold", {7'b0, out_valid}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
